// File: rtl/vx_scoreboard_cnt_if.sv
// Issue, staging, writeback and status signals of the counted register scoreboard.
interface vx_scoreboard_cnt_if #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned NUM_SRCS  = 3,
  parameter int unsigned MAX_SPAN  = 4,
  parameter int unsigned DATAW     = 64
);
  localparam int unsigned WIS_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned NR_W   = $clog2(NUM_REGS);
  localparam int unsigned SPAN_W = $clog2(MAX_SPAN + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [WIS_W-1:0]           in_wis;
  logic                       in_wb;
  logic [NR_W-1:0]            in_rd;
  logic [SPAN_W-1:0]          in_rd_span;
  logic [NUM_SRCS*NR_W-1:0]   in_rs;
  logic [NUM_SRCS*SPAN_W-1:0] in_rs_span;
  logic [DATAW-1:0]           in_data;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATAW-1:0]           out_data;

  logic                       wb_valid;
  logic                       wb_eop;
  logic [WIS_W-1:0]           wb_wis;
  logic [NR_W-1:0]            wb_rd;
  logic [SPAN_W-1:0]          wb_span;

  logic                       busy;
  logic                       err_underflow;
  logic                       stall_timeout;
  logic [31:0]                stall_cycles;

  modport master (
    output in_valid, in_wis, in_wb, in_rd, in_rd_span, in_rs, in_rs_span, in_data,
    output out_ready, wb_valid, wb_eop, wb_wis, wb_rd, wb_span,
    input  in_ready, out_valid, out_data, busy, err_underflow, stall_timeout, stall_cycles
  );

  modport slave (
    input  in_valid, in_wis, in_wb, in_rd, in_rd_span, in_rs, in_rs_span, in_data,
    input  out_ready, wb_valid, wb_eop, wb_wis, wb_rd, wb_span,
    output in_ready, out_valid, out_data, busy, err_underflow, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/vx_scoreboard_cnt.sv
// Per-slice register scoreboard with counted pending writes, 2-entry skid staging,
// sticky underflow flag and stall watchdog.
module vx_scoreboard_cnt #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned NUM_SRCS  = 3,
  parameter int unsigned MAX_SPAN  = 4,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned WAW_ALLOW = 0,
  parameter int unsigned DATAW     = 64,
  parameter int unsigned TIMEOUT   = 65536
) (
  input logic            clk,
  input logic            reset_n,
  vx_scoreboard_cnt_if.slave sb
);
  localparam int unsigned WIS_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned NR_W   = $clog2(NUM_REGS);
  localparam int unsigned SPAN_W = $clog2(MAX_SPAN + 1);
  localparam logic [CTR_W-1:0] CMAX = '1;

  // Registers past NUM_REGS never match because r only iterates over real registers.
  function automatic logic in_span(int unsigned r, logic [NR_W-1:0] base,
                                   logic [SPAN_W-1:0] span);
    return (r >= 32'(base)) && (r < 32'(base) + 32'(span));
  endfunction

  logic [CTR_W-1:0] ctr_q    [NUM_SLOTS][NUM_REGS];
  logic [CTR_W-1:0] ctr_d    [NUM_SLOTS][NUM_REGS];
  logic [CTR_W-1:0] slot_ctr [NUM_REGS];

  logic [1:0]       cnt_q, cnt_d;
  logic [DATAW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic             err_q, err_d;
  logic [31:0]      stall_q, stall_d;

  logic src_busy, dst_busy, stg_ready, fire, pop, release_w, any_busy;

  // Counters of the issuing slot, used by the hazard check.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) slot_ctr[r] = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (sb.in_wis == WIS_W'(s)) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) slot_ctr[r] = ctr_q[s][r];
      end
    end
  end

  always_comb begin
    src_busy = 1'b0;
    dst_busy = 1'b0;
    for (int unsigned k = 0; k < NUM_SRCS; k++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (in_span(r, sb.in_rs[k*NR_W +: NR_W], sb.in_rs_span[k*SPAN_W +: SPAN_W]) &&
            slot_ctr[r] != '0) begin
          src_busy = 1'b1;
        end
      end
    end
    if (sb.in_wb) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (in_span(r, sb.in_rd, sb.in_rd_span)) begin
          if (WAW_ALLOW != 0) begin
            if (slot_ctr[r] == CMAX) dst_busy = 1'b1;
          end else if (slot_ctr[r] != '0) begin
            dst_busy = 1'b1;
          end
        end
      end
    end
  end

  assign stg_ready   = (cnt_q != 2'd2);
  assign sb.in_ready = stg_ready && !src_busy && !dst_busy;
  assign fire        = sb.in_valid && sb.in_ready;
  assign pop         = (cnt_q != 2'd0) && sb.out_ready;
  assign release_w   = sb.wb_valid && sb.wb_eop;

  always_comb begin
    err_d    = err_q;
    any_busy = 1'b0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        logic inc, dec;
        ctr_d[s][r] = ctr_q[s][r];
        inc = fire && sb.in_wb && (sb.in_wis == WIS_W'(s)) &&
              in_span(r, sb.in_rd, sb.in_rd_span);
        dec = release_w && (sb.wb_wis == WIS_W'(s)) && in_span(r, sb.wb_rd, sb.wb_span);
        if (inc && !dec) begin
          if (ctr_q[s][r] != CMAX) ctr_d[s][r] = ctr_q[s][r] + 1'b1;
        end else if (dec && !inc) begin
          if (ctr_q[s][r] == '0) err_d = 1'b1;
          else                   ctr_d[s][r] = ctr_q[s][r] - 1'b1;
        end
        if (ctr_q[s][r] != '0) any_busy = 1'b1;
      end
    end
  end

  // Two-entry skid buffer: d0 is always the head presented downstream.
  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    unique case ({fire, pop})
      2'b10: begin
        if (cnt_q == 2'd0) d0_d = sb.in_data;
        else               d1_d = sb.in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = sb.in_data;
        end else begin
          d0_d = d1_q;
          d1_d = sb.in_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (fire)                                            stall_d = '0;
    else if (sb.in_valid && !sb.in_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) ctr_q[s][r] <= '0;
      end
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
    d0_q <= d0_d;
    d1_q <= d1_d;
  end

  assign sb.out_valid     = (cnt_q != 2'd0);
  assign sb.out_data      = d0_q;
  assign sb.busy          = any_busy;
  assign sb.err_underflow = err_q;
  assign sb.stall_cycles  = stall_q;
  assign sb.stall_timeout = (stall_q >= TIMEOUT);
endmodule

// File: tb/tb_vx_scoreboard_cnt.sv
// Directed bench: dut0 blocks WAW, dut1 allows counted WAW; both see identical stimulus.
module tb_vx_scoreboard_cnt;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_scoreboard_cnt_if if0 ();
  vx_scoreboard_cnt_if if1 ();

  assign if1.in_valid   = if0.in_valid;
  assign if1.in_wis     = if0.in_wis;
  assign if1.in_wb      = if0.in_wb;
  assign if1.in_rd      = if0.in_rd;
  assign if1.in_rd_span = if0.in_rd_span;
  assign if1.in_rs      = if0.in_rs;
  assign if1.in_rs_span = if0.in_rs_span;
  assign if1.in_data    = if0.in_data;
  assign if1.out_ready  = if0.out_ready;
  assign if1.wb_valid   = if0.wb_valid;
  assign if1.wb_eop     = if0.wb_eop;
  assign if1.wb_wis     = if0.wb_wis;
  assign if1.wb_rd      = if0.wb_rd;
  assign if1.wb_span    = if0.wb_span;

  vx_scoreboard_cnt #(.WAW_ALLOW(0), .TIMEOUT(40)) dut0 (
    .clk(clk), .reset_n(reset_n), .sb(if0)
  );
  vx_scoreboard_cnt #(.WAW_ALLOW(1), .TIMEOUT(40)) dut1 (
    .clk(clk), .reset_n(reset_n), .sb(if1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit v, bit [1:0] wis, bit wb, bit [5:0] rd, bit [2:0] rds,
                        bit [17:0] rs, bit [8:0] rss, bit [63:0] d);
    if0.in_valid = v; if0.in_wis = wis; if0.in_wb = wb; if0.in_rd = rd;
    if0.in_rd_span = rds; if0.in_rs = rs; if0.in_rs_span = rss; if0.in_data = d;
  endtask

  task automatic set_wb(bit v, bit eop, bit [1:0] wis, bit [5:0] rd, bit [2:0] sp);
    if0.wb_valid = v; if0.wb_eop = eop; if0.wb_wis = wis; if0.wb_rd = rd; if0.wb_span = sp;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0);
    if0.out_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid got %b want 0", if0.out_valid); end
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy got %b want 0", if0.busy); end
    n_cmp++; if (if0.err_underflow !== 1'b0) begin n_err++;
      $display("FAIL reset_err got %b want 0", if0.err_underflow); end
    n_cmp++; if (if0.stall_cycles !== 32'd0) begin n_err++;
      $display("FAIL reset_stall got %0d want 0", if0.stall_cycles); end
    n_cmp++; if (if0.stall_timeout !== 1'b0) begin n_err++;
      $display("FAIL reset_timeout got %b want 0", if0.stall_timeout); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready got %b want 1", if0.in_ready); end
  endtask

  task automatic test_raw();
    do_reset();
    set_in(1, 0, 1, 5, 1, 0, 0, 64'hA1);
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL raw_first_ready got %b want 1", if0.in_ready); end
    step();
    set_in(1, 0, 0, 0, 1, 18'd5, 9'd1, 64'hA2);
    #1;
    n_cmp++; if (if0.out_valid !== 1'b1 || if0.out_data !== 64'hA1) begin n_err++;
      $display("FAIL raw_staged got %b/%h want 1/a1", if0.out_valid, if0.out_data); end
    n_cmp++; if (if0.busy !== 1'b1) begin n_err++;
      $display("FAIL raw_busy got %b want 1", if0.busy); end
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++;
      $display("FAIL raw_stall got %b want 0", if0.in_ready); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (if0.stall_cycles !== 32'(i)) begin n_err++;
        $display("FAIL raw_stall_count got %0d want %0d", if0.stall_cycles, i); end
    end
    set_wb(1, 1, 0, 5, 1);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0) begin n_err++;
      $display("FAIL raw_released got ready=%b busy=%b want 1/0", if0.in_ready, if0.busy); end
    n_cmp++; if (if0.stall_cycles !== 32'd4) begin n_err++;
      $display("FAIL raw_no_bypass got %0d want 4", if0.stall_cycles); end
    step();
    if0.in_valid = 1'b0;
    #1;
    n_cmp++; if (if0.stall_cycles !== 32'd0) begin n_err++;
      $display("FAIL raw_stall_clear got %0d want 0", if0.stall_cycles); end
    n_cmp++; if (if0.out_valid !== 1'b1 || if0.out_data !== 64'hA2) begin n_err++;
      $display("FAIL raw_read_out got %b/%h want 1/a2", if0.out_valid, if0.out_data); end
    step();
  endtask

  task automatic test_span();
    do_reset();
    set_in(1, 0, 1, 8, 4, 0, 0, 64'hB1);
    step();
    set_in(1, 0, 0, 0, 1, {6'd12, 6'd0, 6'd0}, {3'd1, 3'd0, 3'd0}, 64'hB2);
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL span_rs12_free got %b want 1", if0.in_ready); end
    if0.in_rs = {6'd11, 6'd0, 6'd0};
    #1;
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++;
      $display("FAIL span_rs11_busy got %b want 0", if0.in_ready); end
    if0.in_rs = {6'd0, 6'd0, 6'd10};
    if0.in_rs_span = 9'd1;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++;
      $display("FAIL span_rs10_busy got %b want 0", if0.in_ready); end
    set_wb(1, 1, 0, 8, 4);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if0.busy !== 1'b0 || if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL span_release got busy=%b ready=%b want 0/1", if0.busy, if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    step();
  endtask

  task automatic test_waw();
    bit exp0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit exp1 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_in(1, 0, 1, 3, 1, 0, 0, 64'hC0);
    for (int t = 0; t < 4; t++) begin
      #1;
      n_cmp++; if (if0.in_ready !== exp0[t]) begin n_err++;
        $display("FAIL waw0_ready[%0d] got %b want %b", t, if0.in_ready, exp0[t]); end
      n_cmp++; if (if1.in_ready !== exp1[t]) begin n_err++;
        $display("FAIL waw1_ready[%0d] got %b want %b", t, if1.in_ready, exp1[t]); end
      step();
    end
    set_wb(1, 1, 0, 3, 1);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++;
      $display("FAIL waw1_after_release got %b want 1", if1.in_ready); end
    if0.in_valid = 1'b0;
    step();
  endtask

  task automatic test_same_cycle_and_underflow();
    do_reset();
    set_in(1, 0, 1, 7, 1, 0, 0, 64'hD0);
    step();
    set_wb(1, 1, 0, 7, 1);
    #1;
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++;
      $display("FAIL same_ready got %b want 1", if1.in_ready); end
    step();
    set_wb(0, 0, 0, 0, 0);
    if0.in_valid = 1'b0;
    #1;
    n_cmp++; if (if1.busy !== 1'b1) begin n_err++;
      $display("FAIL same_net_busy got %b want 1", if1.busy); end
    set_wb(1, 1, 0, 7, 1);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if1.busy !== 1'b0 || if1.err_underflow !== 1'b0) begin n_err++;
      $display("FAIL same_single_left got busy=%b err=%b want 0/0", if1.busy,
               if1.err_underflow); end
    do_reset();
    set_wb(1, 0, 0, 20, 1);
    step();
    #1;
    n_cmp++; if (if0.err_underflow !== 1'b0) begin n_err++;
      $display("FAIL uf_non_eop got %b want 0", if0.err_underflow); end
    set_wb(1, 1, 0, 20, 1);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if0.err_underflow !== 1'b1 || if0.busy !== 1'b0) begin n_err++;
      $display("FAIL uf_set got err=%b busy=%b want 1/0", if0.err_underflow, if0.busy); end
    step();
    step();
    n_cmp++; if (if0.err_underflow !== 1'b1) begin n_err++;
      $display("FAIL uf_sticky got %b want 1", if0.err_underflow); end
  endtask

  task automatic test_edge_span();
    do_reset();
    set_in(1, 0, 1, 62, 4, 0, 0, 64'hE0);
    step();
    set_in(0, 0, 0, 0, 1, 18'd63, 9'd1, 0);
    #1;
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_err++;
      $display("FAIL edge_r63_busy got %b want 0", if0.in_ready); end
    if0.in_rs = 18'd0;
    if0.in_rs_span = 9'd2;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL edge_no_wrap got %b want 1", if0.in_ready); end
    if0.in_rs = 18'd61;
    if0.in_rs_span = 9'd1;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL edge_r61_free got %b want 1", if0.in_ready); end
    set_wb(1, 1, 0, 62, 4);
    step();
    set_wb(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (if0.busy !== 1'b0 || if0.err_underflow !== 1'b0) begin n_err++;
      $display("FAIL edge_release got busy=%b err=%b want 0/0", if0.busy,
               if0.err_underflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if0.out_ready = 1'b0;
    set_in(1, 0, 0, 0, 1, 0, 0, 64'hF0);
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL skid_first got %b want 1", if0.in_ready); end
    step();
    if0.in_data = 64'hF1;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1 || if0.out_data !== 64'hF0) begin n_err++;
      $display("FAIL skid_second got %b/%h want 1/f0", if0.in_ready, if0.out_data); end
    step();
    if0.in_data = 64'hF2;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b0 || if0.out_data !== 64'hF0) begin n_err++;
      $display("FAIL skid_full got %b/%h want 0/f0", if0.in_ready, if0.out_data); end
    step();
    if0.out_ready = 1'b1;
    step();
    n_cmp++; if (if0.out_data !== 64'hF1 || if0.in_ready !== 1'b1) begin n_err++;
      $display("FAIL skid_order1 got %h/%b want f1/1", if0.out_data, if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    #1;
    n_cmp++; if (if0.out_data !== 64'hF2 || if0.out_valid !== 1'b1) begin n_err++;
      $display("FAIL skid_order2 got %h/%b want f2/1", if0.out_data, if0.out_valid); end
    step();
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_err++;
      $display("FAIL skid_drained got %b want 0", if0.out_valid); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_in(1, 0, 1, 1, 1, 0, 0, 64'h11);
    step();
    set_in(1, 0, 0, 0, 1, 18'd1, 9'd1, 64'h12);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 39) begin
        n_cmp++; if (if0.stall_timeout !== 1'b0) begin n_err++;
          $display("FAIL wd_early got %b want 0", if0.stall_timeout); end
      end
      if (i == 40) begin
        n_cmp++; if (if0.stall_timeout !== 1'b1 || if0.stall_cycles !== 32'd40) begin
          n_err++;
          $display("FAIL wd_trip got %b/%0d want 1/40", if0.stall_timeout,
                   if0.stall_cycles); end
      end
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    if0.in_valid = 1'b0;
    #1;
    n_cmp++; if (if0.stall_timeout !== 1'b0 || if0.stall_cycles !== 32'd0) begin n_err++;
      $display("FAIL wd_reset got %b/%0d want 0/0", if0.stall_timeout, if0.stall_cycles); end
    n_cmp++; if (if0.busy !== 1'b0 || if0.out_valid !== 1'b0) begin n_err++;
      $display("FAIL wd_reset_state got busy=%b ov=%b want 0/0", if0.busy, if0.out_valid); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_span();
    test_waw();
    test_same_cycle_and_underflow();
    test_edge_span();
    test_back_to_back();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit");
  end
endmodule
